// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage registers: occupancy
// encoding, default field widths and per-stage control-bit positions.
package pipe_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  localparam int unsigned CTRL_W_DEF = 16;
  localparam int unsigned DATA_W_DEF = 128;
  localparam int unsigned CNT_W_DEF  = 16;

  // ID/EX control field layout
  localparam int unsigned IDEX_REGWR        = 0;
  localparam int unsigned IDEX_MEMWR        = 1;
  localparam int unsigned IDEX_MEMRD        = 2;
  localparam int unsigned IDEX_ALUSRC       = 3;
  localparam int unsigned IDEX_ALUFUN_LSB   = 4;
  localparam int unsigned IDEX_ALUFUN_W     = 6;
  localparam int unsigned IDEX_BRANCH       = 10;
  localparam int unsigned IDEX_JUMP         = 11;
  localparam int unsigned IDEX_MEMTOREG_LSB = 12;
  localparam int unsigned IDEX_MEMTOREG_W   = 2;

  // EX/MEM control field layout
  localparam int unsigned EXMEM_REGWR        = 0;
  localparam int unsigned EXMEM_MEMWR        = 1;
  localparam int unsigned EXMEM_MEMRD        = 2;
  localparam int unsigned EXMEM_MEMTOREG_LSB = 3;
  localparam int unsigned EXMEM_MEMTOREG_W   = 2;

  // MEM/WB control field layout
  localparam int unsigned MEMWB_REGWR        = 0;
  localparam int unsigned MEMWB_MEMTOREG_LSB = 1;
  localparam int unsigned MEMWB_MEMTOREG_W   = 2;

  function automatic logic occ_has_entry(input occ_e occ);
    return occ != OCC_EMPTY;
  endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter for stage performance statistics; holds at all-ones.
module pipe_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register with a 2-entry skid buffer and flush.
// Optional stall/bubble counters are built when PIPE_PERF_CNT_EN is defined.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// OCC_EMPTY | no entry held; output is a bubble
// OCC_ONE   | main register holds the output entry; skid empty
// OCC_FULL  | main and skid both hold entries; in_ready low
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W     = CTRL_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter bit          CLEAR_DATA = 1'b1,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  occ_e              state_q, state_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              in_ready_q;
  logic              out_valid_w;

  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;

    if (flush) begin
      state_d     = OCC_EMPTY;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
      if (CLEAR_DATA) begin
        main_data_d = '0;
        skid_data_d = '0;
      end
    end else begin
      case (state_q)
        OCC_EMPTY: begin
          if (in_valid) begin
            state_d     = OCC_ONE;
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end
        end
        OCC_ONE: begin
          if (in_valid && out_ready) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end else if (in_valid) begin
            state_d     = OCC_FULL;
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
          end else if (out_ready) begin
            // data left in place; only ctrl must read zero on a bubble
            state_d     = OCC_EMPTY;
            main_ctrl_d = '0;
          end
        end
        OCC_FULL: begin
          if (out_ready) begin
            state_d     = OCC_ONE;
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
            skid_ctrl_d = '0;
            if (CLEAR_DATA) begin
              skid_data_d = '0;
            end
          end
        end
        default: begin
          state_d     = OCC_EMPTY;
          main_ctrl_d = '0;
          skid_ctrl_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= OCC_EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      // registered so out_ready never reaches in_ready combinationally
      in_ready_q  <= (state_d != OCC_FULL);
    end
  end

  assign out_valid_w = occ_has_entry(state_q);
  assign out_valid   = out_valid_w;
  assign in_ready    = in_ready_q;
  assign out_ctrl    = main_ctrl_q;
  assign out_data    = main_data_q;

`ifdef PIPE_PERF_CNT_EN
  pipe_sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .en_i  (out_valid_w & ~out_ready),
    .cnt_o (stall_cnt)
  );

  pipe_sat_counter #(
    .CNT_W (CNT_W)
  ) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .en_i  (~out_valid_w),
    .cnt_o (bubble_cnt)
  );
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: driver pushes expected entries,
// a negedge monitor pops and compares on every output transfer.
module tb_pipe_stage_reg;

`ifdef PIPE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [15:0]  in_ctrl;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [15:0]  out_ctrl;
  logic [127:0] out_data;
  logic [3:0]   stall_cnt;
  logic [3:0]   bubble_cnt;

  logic         nd_flush;
  logic         nd_in_valid;
  logic         nd_in_ready;
  logic [7:0]   nd_in_ctrl;
  logic [31:0]  nd_in_data;
  logic         nd_out_valid;
  logic         nd_out_ready;
  logic [7:0]   nd_out_ctrl;
  logic [31:0]  nd_out_data;
  logic [3:0]   nd_stall_cnt;
  logic [3:0]   nd_bubble_cnt;

  int checks = 0;
  int errors = 0;
  logic [143:0] exp_q[$];

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .CTRL_W(16), .DATA_W(128), .CLEAR_DATA(1'b1), .CNT_W(4)
  ) u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  pipe_stage_reg #(
    .CTRL_W(8), .DATA_W(32), .CLEAR_DATA(1'b0), .CNT_W(4)
  ) u_nd (
    .clk(clk), .rst(rst), .flush(nd_flush),
    .in_valid(nd_in_valid), .in_ready(nd_in_ready), .in_ctrl(nd_in_ctrl), .in_data(nd_in_data),
    .out_valid(nd_out_valid), .out_ready(nd_out_ready), .out_ctrl(nd_out_ctrl), .out_data(nd_out_data),
    .stall_cnt(nd_stall_cnt), .bubble_cnt(nd_bubble_cnt)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Present one entry, wait (bounded) for in_ready, log the expectation, clock it in.
  task automatic send(input logic [15:0] c, input logic [127:0] d);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_ctrl  = c;
    in_data  = d;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout ctrl=%0h in_ready=%0b required=1", c, in_ready);
    end else begin
      exp_q.push_back({c, d});
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Monitor: every output transfer must match the head of the scoreboard.
  initial begin
    logic [143:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (!out_valid && out_ctrl != 16'h0) begin
          checks++;
          errors++;
          $display("FAIL bubble_ctrl actual=%0h required=0", out_ctrl);
        end
        if (out_valid && out_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected actual_ctrl=%0h required=no_output", out_ctrl);
          end else begin
            e = exp_q.pop_front();
            if ({out_ctrl, out_data} !== e) begin
              errors++;
              $display("FAIL sb_entry actual_ctrl=%0h data=%0h required_ctrl=%0h data=%0h",
                       out_ctrl, out_data, e[143:128], e[127:0]);
            end
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b0;
    flush        = 1'b0;
    in_valid     = 1'b1;
    in_ctrl      = 16'hFFFF;
    in_data      = {4{32'hFFFF_FFFF}};
    out_ready    = 1'b1;
    nd_flush     = 1'b0;
    nd_in_valid  = 1'b0;
    nd_in_ctrl   = 8'h0;
    nd_in_data   = 32'h0;
    nd_out_ready = 1'b0;

    // reset with an input waiting: nothing may be captured
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_ctrl", out_ctrl, 0);
    check("rst_out_data", out_data, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_stall_cnt", stall_cnt, 0);
    @(posedge clk); #1;

    // streaming: 1-cycle latency, in_ready stays high
    for (int i = 1; i <= 4; i++) begin
      send(16'(i), {4{32'hA000_0000 + 32'(i)}});
      check("stream_valid", out_valid, 1);
      check("stream_ctrl", out_ctrl, 16'(i));
      check("stream_in_ready", in_ready, 1);
    end
    @(posedge clk); #1;
    check("stream_drain_valid", out_valid, 0);

    // backpressure: A then B fill the stage, C waits upstream
    out_ready = 1'b0;
    send(16'h00AA, {4{32'h0000_00AA}});
    send(16'h00BB, {4{32'h0000_00BB}});
    check("bp_full_in_ready", in_ready, 0);
    check("bp_head_ctrl", out_ctrl, 16'h00AA);
    fork
      send(16'h00CC, {4{32'h0000_00CC}});
      begin
        repeat (3) @(posedge clk);
        #1;
        check("bp_hold_in_ready", in_ready, 0);
        check("bp_hold_ctrl", out_ctrl, 16'h00AA);
        check("bp_hold_data", out_data, {4{32'h0000_00AA}});
        out_ready = 1'b1;
      end
    join
    repeat (3) @(posedge clk);
    #1;
    check("bp_drained", exp_q.size(), 0);

    // flush while FULL with D presented: D and held entries vanish
    out_ready = 1'b0;
    send(16'h00E1, {4{32'h0000_00E1}});
    send(16'h00F2, {4{32'h0000_00F2}});
    check("fl_full_in_ready", in_ready, 0);
    in_valid = 1'b1;
    in_ctrl  = 16'h00DD;
    in_data  = {4{32'h0000_00DD}};
    flush    = 1'b1;
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    check("fl_out_valid", out_valid, 0);
    check("fl_out_ctrl", out_ctrl, 0);
    check("fl_out_data", out_data, 0);
    check("fl_in_ready", in_ready, 1);
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("fl_no_output", out_valid, 0);

    // CLEAR_DATA=0 instance keeps data across flush
    nd_in_valid = 1'b1;
    nd_in_ctrl  = 8'h5A;
    nd_in_data  = 32'hDEADBEEF;
    @(posedge clk); #1;
    nd_in_valid = 1'b0;
    check("nd_loaded_valid", nd_out_valid, 1);
    check("nd_loaded_data", nd_out_data, 32'hDEADBEEF);
    nd_flush = 1'b1;
    @(posedge clk); #1;
    nd_flush = 1'b0;
    check("nd_fl_valid", nd_out_valid, 0);
    check("nd_fl_ctrl", nd_out_ctrl, 0);
    check("nd_fl_data", nd_out_data, 32'hDEADBEEF);
    check("nd_fl_in_ready", nd_in_ready, 1);

    // reset mid-operation, then counters from a clean start
    out_ready = 1'b0;
    send(16'h0077, {4{32'h0000_0077}});
    check("mid_valid_before_rst", out_valid, 1);
    rst = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    out_ready = 1'b1;
    rst       = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_ctrl", out_ctrl, 0);
    check("mid_rst_in_ready", in_ready, 1);
    repeat (3) @(posedge clk);
    #1;
    check("cnt_bubble_3", bubble_cnt, PERF ? 4'd3 : 4'd0);
    out_ready = 1'b0;
    send(16'h0099, {4{32'h0000_0099}});
    repeat (20) @(posedge clk);
    #1;
    check("cnt_stall_sat", stall_cnt, PERF ? 4'hF : 4'd0);
    check("cnt_bubble_4", bubble_cnt, PERF ? 4'd4 : 4'd0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    exp_q.delete();
    check("cnt_fl_stall", stall_cnt, PERF ? 4'hF : 4'd0);
    check("cnt_fl_bubble", bubble_cnt, PERF ? 4'd4 : 4'd0);
    check("cnt_fl_valid", out_valid, 0);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("final_sb_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
